// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial pattern transmitter feeding the sequence-detector link.
// Loads a PAT_W-bit pattern on start, shifts it out MSB-first one bit per clock,
// repeats it reps times (0 means 1) with GAP_CYC idle cycles between copies,
// then pulses done for one cycle. abort returns to IDLE from any state.
// Optional feature macro: SEQ_TX_PARITY_EN appends an even-parity bit to each copy.
module seq_pattern_tx #(
    parameter int unsigned PAT_W    = 3,
    parameter int unsigned GAP_CYC  = 2,
    parameter logic        IDLE_LVL = 1'b0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [3:0]       reps,
    input  logic             abort,
    output logic             tx_bit,
    output logic             tx_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam int unsigned REP_W = 4;
    localparam int unsigned GAP_W = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]       state_q,    state_d;
    logic [PAT_W-1:0] shreg_q,    shreg_d;
    logic [PAT_W-1:0] pat_q,      pat_d;
    logic [CNT_W-1:0] bit_cnt_q,  bit_cnt_d;
    logic [REP_W-1:0] rep_q,      rep_d;
    logic [GAP_W-1:0] gap_q,      gap_d;
    logic             tx_bit_q,   tx_bit_d;
    logic             tx_valid_q, tx_valid_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;
    logic             copy_end;
`ifdef SEQ_TX_PARITY_EN
    logic             parity_q,   parity_d;
    logic             par_sent_q, par_sent_d;
`endif

    // Next-state and next-output logic; tx_bit_d is the bit visible in the next cycle.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        pat_d      = pat_q;
        bit_cnt_d  = bit_cnt_q;
        rep_d      = rep_q;
        gap_d      = gap_q;
        tx_bit_d   = IDLE_LVL;
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        copy_end   = 1'b0;
`ifdef SEQ_TX_PARITY_EN
        parity_d   = parity_q;
        par_sent_d = par_sent_q;
`endif

        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        pat_d      = pattern;
                        shreg_d    = {pattern[PAT_W-2:0], 1'b0};
                        rep_d      = (reps == 4'd0) ? 4'd1 : reps;
                        bit_cnt_d  = CNT_W'(PAT_W - 1);
                        tx_bit_d   = pattern[PAT_W-1];
                        tx_valid_d = 1'b1;
                        busy_d     = 1'b1;
                        state_d    = ST_SHIFT;
`ifdef SEQ_TX_PARITY_EN
                        parity_d   = ^pattern;
                        par_sent_d = 1'b0;
`endif
                    end
                end

                ST_SHIFT: begin
                    busy_d = 1'b1;
                    if (bit_cnt_q != '0) begin
                        // Next pattern bit comes from the top of the shift register.
                        tx_bit_d   = shreg_q[PAT_W-1];
                        tx_valid_d = 1'b1;
                        shreg_d    = {shreg_q[PAT_W-2:0], 1'b0};
                        bit_cnt_d  = bit_cnt_q - CNT_W'(1);
                    end else begin
`ifdef SEQ_TX_PARITY_EN
                        // LSB is on the line: send parity once, then close the copy.
                        if (!par_sent_q) begin
                            tx_bit_d   = parity_q;
                            tx_valid_d = 1'b1;
                            par_sent_d = 1'b1;
                        end else begin
                            copy_end = 1'b1;
                        end
`else
                        copy_end = 1'b1;
`endif
                    end

                    if (copy_end) begin
                        rep_d = rep_q - 4'd1;
                        if (rep_q == 4'd1) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else if (GAP_CYC != 0) begin
                            state_d = ST_GAP;
                            gap_d   = GAP_W'(GAP_CYC - 1);
                        end else begin
                            // Back-to-back copy: reload without a bubble.
                            tx_bit_d   = pat_q[PAT_W-1];
                            tx_valid_d = 1'b1;
                            shreg_d    = {pat_q[PAT_W-2:0], 1'b0};
                            bit_cnt_d  = CNT_W'(PAT_W - 1);
`ifdef SEQ_TX_PARITY_EN
                            par_sent_d = 1'b0;
`endif
                        end
                    end
                end

                ST_GAP: begin
                    busy_d = 1'b1;
                    if (gap_q == 4'd0) begin
                        tx_bit_d   = pat_q[PAT_W-1];
                        tx_valid_d = 1'b1;
                        shreg_d    = {pat_q[PAT_W-2:0], 1'b0};
                        bit_cnt_d  = CNT_W'(PAT_W - 1);
                        state_d    = ST_SHIFT;
`ifdef SEQ_TX_PARITY_EN
                        par_sent_d = 1'b0;
`endif
                    end else begin
                        gap_d = gap_q - 4'd1;
                    end
                end

                ST_DONE: begin
                    state_d = ST_IDLE;
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            pat_q      <= '0;
            bit_cnt_q  <= '0;
            rep_q      <= '0;
            gap_q      <= '0;
            tx_bit_q   <= IDLE_LVL;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            pat_q      <= pat_d;
            bit_cnt_q  <= bit_cnt_d;
            rep_q      <= rep_d;
            gap_q      <= gap_d;
            tx_bit_q   <= tx_bit_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

`ifdef SEQ_TX_PARITY_EN
    // Parity of the captured pattern and whether it has gone out for this copy.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            parity_q   <= 1'b0;
            par_sent_q <= 1'b0;
        end else begin
            parity_q   <= parity_d;
            par_sent_q <= par_sent_d;
        end
    end
`endif

    assign tx_bit   = tx_bit_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: a driver expands each accepted start into the
// expected per-cycle output trace; a negedge monitor pops and compares every cycle.
module tb_seq_pattern_tx;

    localparam int unsigned PAT_W    = 3;
    localparam int unsigned GAP_CYC  = 2;
    localparam logic        IDLE_LVL = 1'b0;

    typedef struct packed {
        logic b;   // tx_bit
        logic v;   // tx_valid
        logic bz;  // busy
        logic d;   // done
    } exp_t;

    localparam exp_t IDLE_E = '{b: IDLE_LVL, v: 1'b0, bz: 1'b0, d: 1'b0};

    logic             CLK;
    logic             RST_N;
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [3:0]       reps;
    logic             abort;
    logic             tx_bit;
    logic             tx_valid;
    logic             busy;
    logic             done;

    exp_t exp_q[$];
    int   n_cmp;
    int   n_err;

    seq_pattern_tx #(
        .PAT_W   (PAT_W),
        .GAP_CYC (GAP_CYC),
        .IDLE_LVL(IDLE_LVL)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .start   (start),
        .pattern (pattern),
        .reps    (reps),
        .abort   (abort),
        .tx_bit  (tx_bit),
        .tx_valid(tx_valid),
        .busy    (busy),
        .done    (done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got {bit,valid,busy,done}=%b expected %b",
                     name, $time, act, exp);
        end
    endtask

    // Reference trace of a whole transfer, built from the copy/gap/done rules.
    function automatic void push_transfer(input logic [PAT_W-1:0] p, input logic [3:0] r);
        int   n;
        exp_t e;
        n = (r == 4'd0) ? 1 : int'(r);
        for (int c = 0; c < n; c++) begin
            for (int i = PAT_W - 1; i >= 0; i--) begin
                e = '{b: p[i], v: 1'b1, bz: 1'b1, d: 1'b0};
                exp_q.push_back(e);
            end
`ifdef SEQ_TX_PARITY_EN
            e = '{b: ^p, v: 1'b1, bz: 1'b1, d: 1'b0};
            exp_q.push_back(e);
`endif
            if (c < n - 1) begin
                for (int g = 0; g < int'(GAP_CYC); g++) begin
                    e = '{b: IDLE_LVL, v: 1'b0, bz: 1'b1, d: 1'b0};
                    exp_q.push_back(e);
                end
            end
        end
        e = '{b: IDLE_LVL, v: 1'b0, bz: 1'b1, d: 1'b1};
        exp_q.push_back(e);
    endfunction

    // Drive one cycle of inputs just after the edge and update the model.
    // Queue front (if any) is the expectation for the current cycle.
    task automatic do_cycle(input logic s, input logic [PAT_W-1:0] p,
                            input logic [3:0] r, input logic a);
        logic busy_now;
        exp_t keep;
        @(posedge CLK);
        #1;
        start   = s;
        pattern = p;
        reps    = r;
        abort   = a;
        busy_now = (exp_q.size() > 0) && exp_q[0].bz;
        if (a) begin
            if (exp_q.size() > 1) begin
                keep = exp_q[0];
                exp_q.delete();
                exp_q.push_back(keep);
            end
        end else if (s && !busy_now) begin
            if (exp_q.size() == 0) exp_q.push_back(IDLE_E);
            push_transfer(p, r);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, PAT_W'($urandom), 4'($urandom), 1'b0);
    endtask

    // Reset asserted mid-cycle: outputs must clear immediately.
    task automatic mid_reset();
        @(posedge CLK);
        #2;
        RST_N = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        #1;
        check("mid_reset", {tx_bit, tx_valid, busy, done}, IDLE_E);
        exp_q.delete();
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
    endtask

    // Monitor: every cycle out of reset compares against the scoreboard.
    always @(negedge CLK) begin
        exp_t e;
        if (RST_N) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else                  e = IDLE_E;
            check("cycle", {tx_bit, tx_valid, busy, done}, e);
        end
    end

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        RST_N   = 1'b0;
        start   = 1'b0;
        pattern = '0;
        reps    = '0;
        abort   = 1'b0;
        #3;
        check("reset", {tx_bit, tx_valid, busy, done}, IDLE_E);
        #9;
        RST_N = 1'b1;

        // Single copy of the detected sequence.
        do_cycle(1'b1, 3'b100, 4'd1, 1'b0);
        idle_cycles(6);
        // Two copies with gap.
        do_cycle(1'b1, 3'b101, 4'd2, 1'b0);
        idle_cycles(12);
        // reps=0 acts as 1; start during SHIFT ignored.
        do_cycle(1'b1, 3'b110, 4'd0, 1'b0);
        do_cycle(1'b1, 3'b011, 4'd3, 1'b0);
        idle_cycles(6);
        // Start during DONE is ignored, start in the following IDLE cycle is taken.
        do_cycle(1'b1, 3'b001, 4'd1, 1'b0);
        idle_cycles(2);
        do_cycle(1'b1, 3'b111, 4'd1, 1'b0);
        do_cycle(1'b1, 3'b010, 4'd1, 1'b0);
        idle_cycles(6);
        // Abort on the second bit, then restart one cycle later.
        do_cycle(1'b1, 3'b110, 4'd1, 1'b0);
        idle_cycles(1);
        do_cycle(1'b0, 3'b000, 4'd0, 1'b1);
        do_cycle(1'b1, 3'b011, 4'd1, 1'b0);
        idle_cycles(6);
        // Abort together with start in IDLE: start dropped.
        do_cycle(1'b1, 3'b111, 4'd2, 1'b1);
        idle_cycles(3);
        // Abort during a gap.
        do_cycle(1'b1, 3'b101, 4'd3, 1'b0);
        idle_cycles(3);
        do_cycle(1'b0, 3'b000, 4'd0, 1'b1);
        idle_cycles(3);
        // Reset mid-transfer.
        do_cycle(1'b1, 3'b111, 4'd3, 1'b0);
        idle_cycles(1);
        mid_reset();
        idle_cycles(3);
        do_cycle(1'b1, 3'b100, 4'd1, 1'b0);
        idle_cycles(6);

        // Randomized traffic with occasional aborts and long repeat counts.
        for (int k = 0; k < 4000; k++) begin
            logic       s;
            logic       a;
            logic [3:0] r;
            s = ($urandom_range(0, 3) == 0);
            a = ($urandom_range(0, 39) == 0);
            r = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15))
                                            : 4'($urandom_range(0, 3));
            do_cycle(s, PAT_W'($urandom), r, a);
        end
        idle_cycles(150);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
